// File: rtl/vm_multi_control_if.sv
// vm_multi_control_if: front-end and dispense/display signals of the vending controller
interface vm_multi_control_if #(
  parameter int N_GOODS  = 4,
  parameter int CREDIT_W = 8
);
  logic                op_start;
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic                cancel;
  logic [N_GOODS-1:0]  buy;
  logic                restock;
  logic                on;
  logic                occupy;
  logic [CREDIT_W-1:0] credit;
  logic                vend_valid;
  logic [2:0]          vend_id;
  logic                ret_coin;
  logic [CREDIT_W-1:0] ret_value;
  logic [N_GOODS-1:0]  sold_out;
  logic                err_soldout;
  logic                err_funds;
  logic [3:0]          status;
  modport master (
    output op_start, coin_valid, coin_value, cancel, buy, restock,
    input  on, occupy, credit, vend_valid, vend_id, ret_coin, ret_value,
           sold_out, err_soldout, err_funds, status
  );
  modport slave (
    input  op_start, coin_valid, coin_value, cancel, buy, restock,
    output on, occupy, credit, vend_valid, vend_id, ret_coin, ret_value,
           sold_out, err_soldout, err_funds, status
  );
endinterface

// File: rtl/vm_multi_control.sv
// vm_multi_control: N-good vending controller with credit, stock, multi-purchase and timeout refund
module vm_multi_control #(
  parameter int                        N_GOODS     = 4,
  parameter int                        CREDIT_W    = 8,
  parameter int                        STOCK_W     = 4,
  parameter logic [N_GOODS*CREDIT_W-1:0] PRICES    = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int                        INIT_STOCK  = 2,
  parameter int                        MAX_CREDIT  = 50,
  parameter int                        TIMEOUT_CYC = 1000
) (
  input logic                clk,
  input logic                rst,
  vm_multi_control_if.slave  bus
);
  localparam logic [1:0] OFF = 2'd0, IDLE = 2'd1, CREDIT = 2'd2, VEND = 2'd3;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CREDIT_W:0] MAXC = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [N_GOODS-1:0][STOCK_W-1:0] FULL = {N_GOODS{STOCK_W'(INIT_STOCK)}};
  logic [1:0]                      state_q, state_d;
  logic [CREDIT_W-1:0]             credit_q, credit_d;
  logic [N_GOODS-1:0][STOCK_W-1:0] stock_q, stock_d;
  logic [TW-1:0]                   timer_q, timer_d;
  logic [N_GOODS-1:0]              buy_q;
  logic                            cancel_q;
  logic                            vend_valid_q, vend_valid_d;
  logic [2:0]                      vend_id_q, vend_id_d;
  logic                            ret_coin_q, ret_coin_d;
  logic [CREDIT_W-1:0]             ret_value_q, ret_value_d;
  logic                            err_soldout_q, err_soldout_d;
  logic                            err_funds_q, err_funds_d;
  logic [N_GOODS-1:0]              buy_edge;
  logic                            cancel_edge, coin;
  logic [CREDIT_W:0]               eff, price;
  int                              k;
  assign buy_edge    = bus.buy & ~buy_q;
  assign cancel_edge = bus.cancel & ~cancel_q;
  assign coin        = bus.coin_valid && bus.coin_value != '0;
  assign eff         = {1'b0, credit_q} + (coin ? {1'b0, bus.coin_value} : '0);
  always_comb begin
    k = 0;
    for (int i = N_GOODS - 1; i >= 0; i--) if (buy_edge[i]) k = i;
    price         = {1'b0, PRICES[k*CREDIT_W +: CREDIT_W]};
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    timer_d       = '0;
    vend_valid_d  = 1'b0;
    vend_id_d     = '0;
    ret_coin_d    = 1'b0;
    ret_value_d   = '0;
    err_soldout_d = 1'b0;
    err_funds_d   = 1'b0;
    case (state_q)
      OFF: state_d = bus.op_start ? IDLE : OFF;
      IDLE: begin
        stock_d = bus.restock ? FULL : stock_q;
        if (coin && {1'b0, bus.coin_value} > MAXC) begin
          ret_coin_d  = 1'b1;
          ret_value_d = bus.coin_value;
        end else if (coin) begin
          state_d  = CREDIT;
          credit_d = bus.coin_value;
        end
      end
      CREDIT: begin
        if (cancel_edge) begin
          ret_coin_d  = 1'b1;
          ret_value_d = eff[CREDIT_W-1:0];
          credit_d    = '0;
          state_d     = IDLE;
        end else if (|buy_edge && stock_q[k] != '0 && eff >= price) begin
          state_d      = VEND;
          credit_d     = CREDIT_W'(eff - price);
          stock_d[k]   = stock_q[k] - STOCK_W'(1);
          vend_valid_d = 1'b1;
          vend_id_d    = 3'(k);
        end else if (|buy_edge || coin) begin
          err_soldout_d = |buy_edge && stock_q[k] == '0;
          err_funds_d   = |buy_edge && stock_q[k] != '0;
          ret_coin_d    = eff > MAXC;
          ret_value_d   = eff > MAXC ? bus.coin_value : '0;
          credit_d      = eff > MAXC ? credit_q : eff[CREDIT_W-1:0];
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          ret_coin_d  = 1'b1;
          ret_value_d = credit_q;
          credit_d    = '0;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d     = credit_q == '0 ? IDLE : CREDIT;
        ret_coin_d  = coin;
        ret_value_d = coin ? bus.coin_value : '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= OFF;
      credit_q      <= '0;
      stock_q       <= FULL;
      timer_q       <= '0;
      buy_q         <= '0;
      cancel_q      <= 1'b0;
      vend_valid_q  <= 1'b0;
      vend_id_q     <= '0;
      ret_coin_q    <= 1'b0;
      ret_value_q   <= '0;
      err_soldout_q <= 1'b0;
      err_funds_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      timer_q       <= timer_d;
      buy_q         <= bus.buy;
      cancel_q      <= bus.cancel;
      vend_valid_q  <= vend_valid_d;
      vend_id_q     <= vend_id_d;
      ret_coin_q    <= ret_coin_d;
      ret_value_q   <= ret_value_d;
      err_soldout_q <= err_soldout_d;
      err_funds_q   <= err_funds_d;
    end
  end
  for (genvar g = 0; g < N_GOODS; g++) assign bus.sold_out[g] = stock_q[g] == '0;
  assign bus.on          = state_q != OFF;
  assign bus.occupy      = state_q == CREDIT || state_q == VEND;
  assign bus.status      = {2'b00, state_q};
  assign bus.credit      = credit_q;
  assign bus.vend_valid  = vend_valid_q;
  assign bus.vend_id     = vend_id_q;
  assign bus.ret_coin    = ret_coin_q;
  assign bus.ret_value   = ret_value_q;
  assign bus.err_soldout = err_soldout_q;
  assign bus.err_funds   = err_funds_q;
endmodule

// File: doc/vm_multi_control.md
# vm_multi_control

Parametrised vending-machine controller: the next generation of the two-good control FSM. It supports N goods with per-good prices and stock counters, and accumulates credit across coins. It adds multi-purchase, sold-out/insufficient-funds flags, overflow rejection of coins and an idle timeout refund. It sits between the coin/keypad front end and the dispense/display logic.

## Interface
- N_GOODS, 4: number of selectable goods (1..8).
- CREDIT_W, 8: width of coin, credit, price and refund values.
- STOCK_W, 4: width of each stock counter.
- PRICES, {8'd20,8'd15,8'd10,8'd5}: packed N_GOODS*CREDIT_W price vector; good i uses bits [i*CREDIT_W +: CREDIT_W].
- INIT_STOCK, 2: stock loaded into every good at reset and on restock.
- MAX_CREDIT, 50: credit ceiling; must be < 2^CREDIT_W.
- TIMEOUT_CYC, 1000: idle cycles in CREDIT before automatic refund.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_start  in  1  power-on request, level; acted on only in OFF.
- coin_valid  in  1  one-cycle strobe: coin_value is valid this cycle.
- coin_value  in  CREDIT_W  inserted coin value; a value of 0 is ignored.
- cancel  in  1  refund request, level; acted on at its rising edge.
- buy  in  N_GOODS  purchase buttons, level; each bit is acted on at its rising edge.
- restock  in  1  one-cycle strobe: reload all stock to INIT_STOCK.
- on  out  1  machine powered.
- occupy  out  1  transaction in progress (CREDIT or VEND).
- credit  out  CREDIT_W  current accumulated credit.
- vend_valid  out  1  one-cycle dispense strobe.
- vend_id  out  3  index of the good dispensed; valid with vend_valid.
- ret_coin  out  1  one-cycle refund strobe.
- ret_value  out  CREDIT_W  refund amount; valid with ret_coin.
- sold_out  out  N_GOODS  bit i set while stock[i]==0.
- err_soldout, err_funds  out  1  one-cycle strobes on a rejected buy.
- status  out  4  state code: OFF=0, IDLE=1, CREDIT=2, VEND=3.

## Operation
- Reset: state OFF, credit 0, every stock loaded to INIT_STOCK. All outputs are 0 except sold_out, which is 0 unless INIT_STOCK==0. Reset mid-transaction discards credit with no refund.
- Rising edges of buy[i] and cancel are detected against a registered copy of each input; the registered copy is cleared on reset.
- OFF: op_start=1 moves to IDLE; on=1 from the following cycle.
- IDLE: coin_valid with a nonzero value moves to CREDIT, credit=coin_value. A value above MAX_CREDIT is rejected instead: ret_coin=1, ret_value=coin_value. restock reloads all stock. buy and cancel are ignored.
- CREDIT uses eff = credit + (coin_valid ? coin_value : 0), computed CREDIT_W+1 bits wide. Priority within one cycle is cancel, then buy, then coin.
  - Cancel edge: ret_coin=1, ret_value=eff, credit=0, go to IDLE. A coinciding coin is included in the refund even if eff > MAX_CREDIT.
  - Buy edge: only the lowest set edge index k is served. If stock[k]==0, pulse err_soldout. Else if eff < PRICES[k], pulse err_funds. Otherwise go to VEND: credit=eff-PRICES[k], stock[k] decrements, vend_valid=1, vend_id=k.
  - Rejected buy: credit=eff and the state stays CREDIT. The one exception is eff > MAX_CREDIT: the coin is returned (ret_coin, ret_value=coin_value) and credit is unchanged.
  - Coin only: if eff <= MAX_CREDIT, credit=eff. Otherwise the coin is returned as above.
  - Timeout: a counter clears on every coin, buy edge or cancel edge. When it reaches TIMEOUT_CYC-1 with no event, the block refunds the credit as for cancel.
  - restock is ignored outside IDLE.
- VEND lasts exactly one cycle. The next state is IDLE if credit==0, otherwise CREDIT (multi-purchase). Coins arriving in VEND are returned immediately; buy and cancel edges arriving in VEND are dropped.
- op_start is ignored outside OFF. There is no power-off path other than reset.

## Timing
- All outputs are registered. An event sampled at edge t is visible from t+1.
- vend_valid, vend_id and the updated credit appear together, one cycle after the buy edge is sampled.
- ret_coin/ret_value, err_soldout and err_funds are single-cycle pulses, one cycle after the cause is sampled. Between pulses ret_value and vend_id hold 0.
- Timeout refund is issued exactly TIMEOUT_CYC cycles after the last event.
- occupy=1 in CREDIT and VEND. on=1 in every state except OFF.

## Test plan
All scenarios use the default parameters.
1. Reset low, then high; op_start pulse; coins 5, 10 -> status 0→1→2, credit 5 then 15, occupy=1.
2. Credit 15, buy[1] edge -> vend_valid=1, vend_id=1, credit 5, state CREDIT. Then cancel -> ret_coin=1, ret_value=5, state IDLE.
3. Credit 10, buy[3] edge -> err_funds=1, credit stays 10. Add coin 10, then buy[3] -> vend_id=3, credit 0, state returns to IDLE.
4. Buy good 0 twice (stock 2→0) -> sold_out[0]=1. A third buy[0] -> err_soldout=1 and credit is unchanged. restock in IDLE -> sold_out=0.
5. Credit 45, coin 10 -> ret_coin=1, ret_value=10, credit stays 45. Coin 5 together with a cancel edge -> ret_value=50.
6. Credit 20, then idle for TIMEOUT_CYC cycles -> refund of 20 exactly on schedule. Reset asserted mid-CREDIT -> outputs 0, status 0, no ret_coin.
